// File: rtl/cla_multiword_add_ctrl.sv
// Multi-word add/subtract sequencer for a shared 16-bit CLA adder.
// Operands are processed one 16-bit word at a time, least significant word
// first. The carry is chained between words through c_r. Each word is held
// on the adder inputs for SETTLE cycles before sum and carry are captured.
module cla_multiword_add_ctrl #(
    parameter int WORDS  = 4,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                carry_in,
    input  logic                sub,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    output logic                add_cin,
    input  logic [15:0]         add_sum,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic                carry_out,
    output logic                ovf,
    output logic                busy
);

    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          c_r;
    logic [IW-1:0] idx;
    logic [IW-1:0] nidx;
    logic [CW-1:0] cnt;
    logic          last_word;
    logic          last_cycle;

    // Request is accepted only when idle and out of reset.
    assign in_ready   = rst_n && (state == S_IDLE);

    // Helper indices for word sequencing and the settle counter.
    assign nidx       = idx + IW'(1);
    assign last_word  = (idx == IW'(WORDS - 1));
    assign last_cycle = (cnt == CW'(SETTLE - 1));

    // Main sequencer: accept, step words through the adder, hold the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    add_a   <= '0;
                    add_b   <= '0;
                    add_cin <= 1'b0;
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        c_r   <= sub ? 1'b1 : carry_in;
                        idx   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SETTLE;
                        // Word 0 goes onto the adder on the accept edge so every
                        // word sees exactly SETTLE cycles of stable inputs.
                        add_a   <= a[15:0];
                        add_b   <= sub ? ~b[15:0] : b[15:0];
                        add_cin <= sub ? 1'b1 : carry_in;
                    end
                end

                S_SETTLE: begin
                    if (last_cycle) begin
                        sum[{idx, 4'h0} +: 16] <= add_sum;
                        c_r <= add_cout;
                        cnt <= '0;
                        if (last_word) begin
                            state   <= S_DONE;
                            add_a   <= '0;
                            add_b   <= '0;
                            add_cin <= 1'b0;
                        end else begin
                            idx     <= nidx;
                            add_a   <= a_r[{nidx, 4'h0} +: 16];
                            add_b   <= b_r[{nidx, 4'h0} +: 16];
                            add_cin <= add_cout;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DONE: begin
                    add_a   <= '0;
                    add_b   <= '0;
                    add_cin <= 1'b0;
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        carry_out <= c_r;
                        ovf       <= (a_r[W-1] == b_r[W-1]) && (sum[W-1] != a_r[W-1]);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Scoreboard bench for cla_multiword_add_ctrl with a behavioural 16-bit adder.
module tb_cla_multiword_add_ctrl;

    localparam int WORDS  = 4;
    localparam int SETTLE = 2;
    localparam int W      = 16 * WORDS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          carry_in;
    logic          sub;
    logic [15:0]   add_a;
    logic [15:0]   add_b;
    logic          add_cin;
    logic [15:0]   add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          carry_out;
    logic          ovf;
    logic          busy;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;

    cla_multiword_add_ctrl #(.WORDS(WORDS), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    // Stand-in for the external gate-level adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares on every completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got sum %h with no expected entry", sum);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum, e.s);
                    chk("carry_out", W'(carry_out), W'(e.c));
                    chk("ovf", W'(ovf), W'(e.o));
                end
            end
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic ts, input logic [W-1:0] es, input logic ec,
                         input logic eo, input bit seq, input bit bp);
        int k;
        exp_t e;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            return;
        end
        if (bp) out_ready = 1'b0;
        a        = ta;
        b        = tb_v;
        carry_in = tc;
        sub      = ts;
        in_valid = 1'b1;
        e.s = es;
        e.c = ec;
        e.o = eo;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        if (seq) chk("seq_add_a_0", W'(add_a), W'(16'h0001));
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (seq && k < 8) chk("seq_add_a", W'(add_a), W'(k / 2 + 1));
        end
        if (seq) chk("seq_add_a_done", W'(add_a), '0);
        chk("latency", W'(k), W'(9));
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("bp_out_valid", W'(out_valid), W'(1));
                chk("bp_sum", sum, es);
                chk("bp_in_ready", W'(in_ready), W'(0));
                in_valid = i[0];
                a        = ~ta;
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            chk("bp_sum_hold", sum, es);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_release_valid", W'(out_valid), W'(0));
            chk("bp_release_ready", W'(in_ready), W'(1));
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_sum", sum, '0);
        chk("rst_add_a", W'(add_a), '0);
        chk("rst_in_ready", W'(in_ready), '0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", W'(in_ready), W'(1));

        do_op(64'd10, 64'd22, 1'b0, 1'b0, 64'd32, 1'b0, 1'b0, 0, 0);
        do_op(64'd10, 64'd22, 1'b1, 1'b0, 64'd33, 1'b0, 1'b0, 0, 0);
        do_op(64'h0004_0003_0002_0001, 64'd0, 1'b0, 1'b0,
              64'h0004_0003_0002_0001, 1'b0, 1'b0, 1, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 0, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 0, 0);
        do_op(64'd32, 64'd10, 1'b1, 1'b1, 64'd22, 1'b1, 1'b0, 0, 0);
        do_op(64'd10, 64'd22, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 1'b0, 0, 0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, 0, 1);

        // Abandon an operation with a one-cycle reset on the third edge after accept.
        @(negedge clk);
        a        = 64'd1;
        b        = 64'd2;
        carry_in = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", W'(out_valid), '0);
        chk("mid_rst_busy", W'(busy), '0);
        chk("mid_rst_sum", sum, '0);
        chk("mid_rst_add_a", W'(add_a), '0);
        chk("mid_rst_add_b", W'(add_b), '0);
        chk("mid_rst_carry_out", W'(carry_out), '0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        do_op(64'd10, 64'd22, 1'b0, 1'b0, 64'd32, 1'b0, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", W'(q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
